// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM FIFO arbiter: a single-word writer and a burst reader share the
// SDRAM controller's write/read FIFOs. Writer wins while vs is high, otherwise round-robin.
module sdram_port_arbiter #(
    parameter int unsigned LD_HOLD = 10,
    parameter int unsigned MAX_LEN = 10,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vs,
    input  logic        w_req,
    input  logic [24:0] w_addr,
    input  logic [15:0] w_data,
    output logic        w_done,
    input  logic        r_req,
    input  logic [24:0] r_addr,
    input  logic [3:0]  r_len,
    output logic        r_valid,
    output logic [15:0] r_data,
    output logic        r_done,
    output logic        write_ld,
    output logic        write_req,
    output logic [24:0] writeaddr,
    output logic [15:0] writedata,
    input  logic [15:0] wr_buffer,
    output logic        read_ld,
    output logic        read_req,
    output logic [24:0] readaddr,
    input  logic [15:0] readdata,
    input  logic [15:0] rd_buffer,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW    = 25;
    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = 4;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + LD_HOLD + MAX_LEN + 2);

    typedef enum logic [2:0] {IDLE, W_LD, W_REQ, W_DRAIN, R_LD, R_WAIT, R_BURST} state_t;

    state_t           state_q, state_d;
    logic             last_rd_q, last_rd_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [LW-1:0]    len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_done_q, w_done_d, r_done_q, r_done_d;
    logic             r_valid_q, r_valid_d;
    logic [DW-1:0]    r_data_q, r_data_d;
    logic             write_ld_q, write_ld_d, write_req_q, write_req_d;
    logic             read_ld_q, read_ld_d, read_req_q, read_req_d;
    logic [AW-1:0]    writeaddr_q, writeaddr_d, readaddr_q, readaddr_d;
    logic [DW-1:0]    writedata_q, writedata_d;
    logic             busy_q, busy_d, err_q, err_d;
    logic             grant_w;
    logic [LW-1:0]    len_clamp;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        w_done_d    = 1'b0;
        r_done_d    = 1'b0;
        write_ld_d  = 1'b0;
        write_req_d = 1'b0;
        read_ld_d   = 1'b0;
        read_req_d  = 1'b0;
        err_d       = err_q;
        r_valid_d   = read_req_q;
        r_data_d    = read_req_q ? readdata : r_data_q;
        grant_w     = w_req && (!r_req || vs || last_rd_q);

        if (r_len == '0) begin
            len_clamp = LW'(1);
        end else if (32'(r_len) > MAX_LEN) begin
            len_clamp = LW'(MAX_LEN);
        end else begin
            len_clamp = r_len;
        end

        case (state_q)
            IDLE: begin
                if (grant_w) begin
                    state_d    = W_LD;
                    last_rd_d  = 1'b0;
                    addr_d     = w_addr;
                    wdata_d    = w_data;
                    write_ld_d = 1'b1;
                end else if (r_req) begin
                    state_d   = R_LD;
                    last_rd_d = 1'b1;
                    addr_d    = r_addr;
                    len_d     = len_clamp;
                    cnt_d     = '0;
                    read_ld_d = 1'b1;
                end
            end
            W_LD: begin
                state_d     = W_REQ;
                write_req_d = 1'b1;
            end
            W_REQ: begin
                // An already-empty FIFO retires the write in the first drain cycle
                state_d  = W_DRAIN;
                cnt_d    = '0;
                w_done_d = (wr_buffer == '0);
            end
            W_DRAIN: begin
                if (w_done_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (wr_buffer == '0) begin
                        w_done_d = 1'b1;
                    end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                        w_done_d = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            R_LD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LD_HOLD - 1)) begin
                    state_d = R_WAIT;
                    cnt_d   = '0;
                end else begin
                    read_ld_d = 1'b1;
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rd_buffer >= DW'(len_q)) begin
                    state_d    = R_BURST;
                    cnt_d      = '0;
                    read_req_d = 1'b1;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    state_d  = IDLE;
                    r_done_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
            R_BURST: begin
                // cnt counts issued read_req cycles; done follows the last delayed valid
                if (cnt_q == CNT_W'(len_q)) begin
                    state_d  = IDLE;
                    r_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    read_req_d = (cnt_q + CNT_W'(1) != CNT_W'(len_q));
                end
            end
            default: state_d = IDLE;
        endcase

        writeaddr_d = (state_d == W_LD)  ? addr_d  : '0;
        writedata_d = (state_d == W_REQ) ? wdata_d : '0;
        readaddr_d  = (state_d == R_LD)  ? addr_d  : '0;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_rd_q   <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            w_done_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            write_ld_q  <= 1'b0;
            write_req_q <= 1'b0;
            read_ld_q   <= 1'b0;
            read_req_q  <= 1'b0;
            writeaddr_q <= '0;
            writedata_q <= '0;
            readaddr_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_rd_q   <= last_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            w_done_q    <= w_done_d;
            r_done_q    <= r_done_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            write_ld_q  <= write_ld_d;
            write_req_q <= write_req_d;
            read_ld_q   <= read_ld_d;
            read_req_q  <= read_req_d;
            writeaddr_q <= writeaddr_d;
            writedata_q <= writedata_d;
            readaddr_q  <= readaddr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign w_done    = w_done_q;
    assign r_done    = r_done_q;
    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign write_ld  = write_ld_q;
    assign write_req = write_req_q;
    assign writeaddr = writeaddr_q;
    assign writedata = writedata_q;
    assign read_ld   = read_ld_q;
    assign read_req  = read_req_q;
    assign readaddr  = readaddr_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: write/read timing, arbitration, clamping,
// timeouts and asynchronous reset, with a small FIFO-side model driving readdata.
module tb_sdram_port_arbiter;

    localparam int unsigned LD_HOLD = 10;
    localparam int unsigned MAX_LEN = 10;
    localparam int unsigned TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs, w_req, r_req;
    logic [24:0] w_addr, r_addr;
    logic [15:0] w_data;
    logic [3:0]  r_len;
    logic [15:0] wr_buffer, rd_buffer, readdata;
    logic        w_done, r_valid, r_done, write_ld, write_req, read_ld, read_req, busy, err;
    logic [15:0] r_data, writedata;
    logic [24:0] writeaddr, readaddr;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ld_cnt, rq_cnt, nv, rdone, wdone, viol, rd_idx, last_valid_cyc, rdone_cyc;
    logic [24:0] first_raddr;
    logic [15:0] rd_base, rd_fill;
    logic [15:0] words [16];
    bit          ok;

    sdram_port_arbiter #(.LD_HOLD(LD_HOLD), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .vs(vs),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_done(w_done),
        .r_req(r_req), .r_addr(r_addr), .r_len(r_len),
        .r_valid(r_valid), .r_data(r_data), .r_done(r_done),
        .write_ld(write_ld), .write_req(write_req), .writeaddr(writeaddr),
        .writedata(writedata), .wr_buffer(wr_buffer),
        .read_ld(read_ld), .read_req(read_req), .readaddr(readaddr),
        .readdata(readdata), .rd_buffer(rd_buffer),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] outs();
        return 128'({w_done, r_valid, r_data, r_done, write_ld, write_req, writeaddr,
                     writedata, read_ld, read_req, readaddr, busy, err});
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        ld_cnt = 0; rq_cnt = 0; nv = 0; rdone = 0; wdone = 0; viol = 0; rd_idx = 0;
        last_valid_cyc = -1; rdone_cyc = -1; first_raddr = '0;
    endtask

    // One clock; sample #1 after the edge, then act as the read FIFO for the next edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (read_ld) begin
            if (ld_cnt == 0) first_raddr = readaddr;
            ld_cnt++;
        end
        if (read_req) begin
            rq_cnt++;
            readdata = rd_base + 16'(rd_idx);
            rd_idx++;
        end
        if (r_valid) begin
            if (nv < 16) words[nv] = r_data;
            nv++;
            last_valid_cyc = cyc;
        end
        if (r_done) begin
            rdone++;
            rdone_cyc = cyc;
        end
        if (w_done) wdone++;
        if (int'(write_ld) + int'(write_req) + int'(read_ld) + int'(read_req) > 1) viol++;
    endtask

    // Run until a done pulse (bounded), then release the requests and settle
    task automatic run_txn(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            step();
            if (!read_ld && ld_cnt > 0) rd_buffer = rd_fill;
            if (w_done || r_done) got = 1'b1;
        end
        w_req = 1'b0; r_req = 1'b0; rd_buffer = '0;
        step();
        step();
    endtask

    task automatic do_read(input logic [24:0] a, input logic [3:0] l, input logic [15:0] fill,
                           input logic [15:0] base, output bit got);
        clear_acc();
        rd_base = base; rd_fill = fill;
        r_addr = a; r_len = l; r_req = 1'b1;
        run_txn(300, got);
    endtask

    task automatic contest(input bit exp_w, input string tag);
        bit got;
        clear_acc();
        rd_base = 16'h0100; rd_fill = 16'd16;
        w_addr = 25'h55; w_data = 16'h1234; r_addr = 25'h66; r_len = 4'd2;
        w_req = 1'b1; r_req = 1'b1;
        step();
        chk({tag, "_write_ld"}, 128'(write_ld), 128'(exp_w));
        chk({tag, "_read_ld"}, 128'(read_ld), 128'(!exp_w));
        run_txn(300, got);
        chk({tag, "_done"}, 128'(got), 128'(1));
    endtask

    initial begin
        reset = 1'b0; vs = 1'b0; w_req = 1'b0; r_req = 1'b0;
        w_addr = '0; w_data = '0; r_addr = '0; r_len = '0;
        wr_buffer = '0; rd_buffer = '0; readdata = '0; rd_base = '0; rd_fill = '0;
        clear_acc();
        step();
        step();
        chk("reset_outputs", outs(), 128'(0));
        reset = 1'b1;
        step();
        chk("idle_outputs", outs(), 128'(0));

        // Single write: load, request, retire with an empty FIFO
        clear_acc();
        w_addr = 25'h2A; w_data = 16'h0FFF; w_req = 1'b1;
        step();
        chk("w1_write_ld", 128'({write_ld, write_req, busy}), 128'(3'b101));
        chk("w1_writeaddr", 128'(writeaddr), 128'(25'h2A));
        w_addr = 25'h1FF; w_data = 16'hBEEF;
        step();
        chk("w2_write_req", 128'({write_ld, write_req}), 128'(2'b01));
        chk("w2_writedata", 128'(writedata), 128'(16'h0FFF));
        step();
        chk("w3_w_done", 128'({w_done, write_req, write_ld}), 128'(3'b100));
        w_req = 1'b0;
        step();
        chk("w4_idle", 128'({w_done, busy}), 128'(2'b00));
        step();
        chk("w_single_done", 128'(wdone), 128'(1));

        // Full 10-word burst
        do_read(25'h3C, 4'd10, 16'd10, 16'hA000, ok);
        chk("r10_done_seen", 128'(ok), 128'(1));
        chk("r10_read_ld_cycles", 128'(ld_cnt), 128'(LD_HOLD));
        chk("r10_readaddr", 128'(first_raddr), 128'(25'h3C));
        chk("r10_read_req_cycles", 128'(rq_cnt), 128'(10));
        chk("r10_valid_words", 128'(nv), 128'(10));
        for (int i = 0; i < 10; i++) chk($sformatf("r10_word%0d", i), 128'(words[i]), 128'(16'hA000 + 16'(i)));
        chk("r10_single_done", 128'(rdone), 128'(1));
        chk("r10_done_after_valid", 128'(rdone_cyc), 128'(last_valid_cyc + 1));
        chk("r10_onehot", 128'(viol), 128'(0));

        // Length clamping
        do_read(25'h10, 4'd0, 16'd16, 16'h0B00, ok);
        chk("rlen0_words", 128'({rq_cnt[7:0], nv[7:0]}), 128'({8'd1, 8'd1}));
        chk("rlen0_word0", 128'(words[0]), 128'(16'h0B00));
        do_read(25'h20, 4'd15, 16'd16, 16'h0C00, ok);
        chk("rlen15_words", 128'({rq_cnt[7:0], nv[7:0]}), 128'({8'd10, 8'd10}));
        chk("rlen15_last", 128'(words[9]), 128'(16'h0C09));

        // Round-robin with vs low (last grant was the reader), then writer priority
        vs = 1'b0;
        contest(1'b1, "rr1");
        contest(1'b0, "rr2");
        contest(1'b1, "rr3");
        vs = 1'b1;
        contest(1'b1, "vs1");
        contest(1'b1, "vs2");
        vs = 1'b0;

        // Write drain timeout with a stuck FIFO
        clear_acc();
        wr_buffer = 16'd1; w_addr = 25'h7; w_data = 16'h7777; w_req = 1'b1;
        step();
        step();
        step();
        chk("wto_entry", 128'({w_done, err, busy}), 128'(3'b001));
        for (int i = 1; i < int'(TIMEOUT); i++) step();
        chk("wto_early_done", 128'(wdone), 128'(0));
        step();
        chk("wto_done_err", 128'({w_done, err}), 128'(2'b11));
        w_req = 1'b0;
        step();
        chk("wto_err_sticky", 128'({w_done, err}), 128'(2'b01));
        #2 reset = 1'b0;
        #1 chk("wto_reset_outputs", outs(), 128'(0));
        step();
        wr_buffer = '0;
        reset = 1'b1;
        step();

        // First contested grant after reset goes to the writer
        contest(1'b1, "post_reset");

        // Read wait timeout: no valid words, one done, err set
        do_read(25'h44, 4'd2, 16'd0, 16'h0D00, ok);
        chk("rto_done_seen", 128'(ok), 128'(1));
        chk("rto_no_data", 128'({rq_cnt[7:0], nv[7:0]}), 128'(0));
        chk("rto_done_err", 128'({rdone[7:0], err}), 128'({8'd1, 1'b1}));

        // Reset in the middle of a burst
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        clear_acc();
        rd_base = 16'h0E00; rd_fill = 16'd16;
        r_addr = 25'h90; r_len = 4'd8; r_req = 1'b1;
        for (int i = 0; i < 200 && nv < 4; i++) begin
            step();
            if (!read_ld && ld_cnt > 0) rd_buffer = rd_fill;
        end
        chk("mid_burst_reached", 128'(nv), 128'(4));
        #2 reset = 1'b0;
        #1 chk("mid_burst_reset_outputs", outs(), 128'(0));
        r_req = 1'b0; rd_buffer = '0;
        step();
        reset = 1'b1;
        step();
        step();
        chk("mid_burst_no_done", 128'(rdone), 128'(0));
        do_read(25'h91, 4'd3, 16'd3, 16'h0F00, ok);
        chk("after_reset_read", 128'({rq_cnt[7:0], nv[7:0], rdone[7:0]}), 128'({8'd3, 8'd3, 8'd1}));
        chk("after_reset_word2", 128'(words[2]), 128'(16'h0F02));
        chk("after_reset_addr", 128'(first_raddr), 128'(25'h91));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter LD_HOLD, default 10, cycles read_ld is held high per read.
REQ-002 SHALL have parameter MAX_LEN, default 10, maximum burst words per read (one board row).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum wait cycles in any FIFO-wait state.
REQ-004 SHALL have ports, each given as name, direction, width and meaning:
- clk  in  1  single clock; all logic rises on posedge clk.
- reset  in  1  asynchronous, active-low (0 = reset).
- vs  in  1  vertical-sync window; writes take priority while high.
- w_req  in  1  writer request, level, held until w_done.
- w_addr  in  25  writer word address.
- w_data  in  16  writer data.
- w_done  out  1  one-cycle pulse, write retired.
- r_req  in  1  reader request, level, held until r_done.
- r_addr  in  25  reader burst start address.
- r_len  in  4  reader burst length in words.
- r_valid  out  1  r_data holds a burst word.
- r_data  out  16  burst word.
- r_done  out  1  one-cycle pulse, burst retired.
- write_ld, write_req  out  1 each  SDRAM write-FIFO load and request.
- writeaddr  out  25, writedata  out  16  SDRAM write address and data.
- wr_buffer  in  16  write-FIFO occupancy.
- read_ld, read_req  out  1 each  SDRAM read-FIFO load and request.
- readaddr  out  25  SDRAM read address.
- readdata  in  16  read-FIFO data.
- rd_buffer  in  16  read-FIFO occupancy.
- busy  out  1  high in any non-IDLE state.
- err  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement the FSM states IDLE, W_LD, W_REQ, W_DRAIN, R_LD, R_WAIT, R_BURST.
REQ-006 IDLE, w_req only: SHALL go to W_LD. r_req only: SHALL go to R_LD.
REQ-007 IDLE, both requests, vs=1: SHALL grant the writer.
REQ-008 IDLE, both requests, vs=0: SHALL grant round-robin, to the requester opposite last_gnt.
REQ-009 A grant SHALL never be preempted, and last_gnt SHALL update on every grant.
REQ-010 The arbiter SHALL latch w_addr/w_data or r_addr/r_len on the grant edge, so later input changes are ignored.
REQ-011 W_LD SHALL drive write_ld=1 and writeaddr=latched address for exactly 1 cycle.
REQ-012 W_REQ SHALL drive write_ld=0, write_req=1 and writedata=latched data for exactly 1 cycle.
REQ-013 W_DRAIN: write_req=0; on wr_buffer==0 the block SHALL pulse w_done and return to IDLE.
- Minimum write latency, grant to w_done: 3 cycles.
REQ-014 r_len SHALL be clamped on latch: 0 becomes 1; values above MAX_LEN become MAX_LEN.
REQ-015 R_LD SHALL drive read_ld=1 and readaddr=latched address for exactly LD_HOLD cycles.
REQ-016 R_WAIT: read_ld=0; when rd_buffer >= clamped length, the block SHALL go to R_BURST.
REQ-017 R_BURST SHALL hold read_req=1 for exactly the clamped-length cycles.
REQ-018 Burst data: r_data SHALL be readdata registered, and r_valid SHALL be read_req delayed 1 cycle.
- Exactly the clamped length of valid words results.
REQ-019 r_done SHALL pulse in the cycle after the last r_valid; the FSM then returns to IDLE.
REQ-020 A wait counter SHALL clear on entry to W_DRAIN or R_WAIT and increment each cycle in those states.
REQ-021 If the wait counter reaches TIMEOUT, the block SHALL set err, pulse the matching done, drop all FIFO strobes and go to IDLE.
- In that case r_valid stays 0.
REQ-022 At most one of write_ld, write_req, read_ld, read_req SHALL be high in any cycle.
REQ-023 A request deasserted before its grant SHALL simply be dropped; after the grant it SHALL be ignored until done.
REQ-024 Strobes SHALL toggle only on the posedge clk edges defined above.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, last_gnt=reader and err=0.
REQ-026 reset=0 SHALL force every output to 0, including mid-burst and mid-drain.
- No done pulse is produced for an aborted transaction.
REQ-027 After reset release, the first contested grant SHALL go to the writer.

Verification
REQ-028 w_req, addr 0x2A, data 0x0FFF, wr_buffer=0 -> write_ld cycle 1 with writeaddr 0x2A; write_req cycle 2 with writedata 0x0FFF; w_done cycle 3.
REQ-029 r_req, addr 0x3C, r_len=10, rd_buffer=10 after read_ld -> read_ld high 10 cycles; read_req 10 cycles; 10 r_valid words in order; single r_done.
REQ-030 Both requests with vs=1, twice in a row -> writer granted both times; with vs=0 -> grants alternate writer, reader, writer.
REQ-031 r_len=0 -> 1 word; r_len=15 -> 10 words.
REQ-032 wr_buffer stuck at 1 -> w_done and err=1 at TIMEOUT cycles after W_DRAIN entry.
- Then reset=0 -> err=0 and all outputs 0.
REQ-033 reset asserted on the 4th burst word -> outputs 0 immediately, no r_done.
- Next r_req is serviced normally.
